// File: rtl/pi_spi_rx_pkg.sv
// Shared types and helpers for the Pi SPI sample receiver.
// Holds FSM state enum, widths and sign-magnitude conversion.
package fx_spi_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    ACTIVE,
    OVERRUN
  } rx_state_t;

  localparam int SAMPLE_W = 12;
  localparam int MAG_W    = 10;

  // 11-bit sign-magnitude frame to 12-bit two's complement.
  // Negative zero maps to 0 since -0 == 0.
  function automatic logic [11:0] sm_to_tc(
    input logic [10:0] f
  );
    logic [11:0] m;
    m = {2'b00, f[9:0]};
    return f[10] ? (~m + 12'd1) : m;
  endfunction

endpackage

// File: rtl/pi_spi_rx_if.sv
// Bundle of SPI pins and recovered-sample outputs.
// master: SPI source / consumer; slave: the receiver.
interface pi_spi_rx_if;
  import fx_spi_pkg::*;

  logic                sclk_in;
  logic                ncs_in;
  logic                sdi;
  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic                frame_err;
  logic                busy;
  logic [MAG_W-1:0]    peak_mag;

  modport master (
    output sclk_in,
    output ncs_in,
    output sdi,
    input  sample,
    input  sample_valid,
    input  frame_err,
    input  busy,
    input  peak_mag
  );

  modport slave (
    input  sclk_in,
    input  ncs_in,
    input  sdi,
    output sample,
    output sample_valid,
    output frame_err,
    output busy,
    output peak_mag
  );

endinterface

// File: rtl/pi_spi_rx_sync.sv
// N-stage synchronizer with rise/fall detect on the synced copy.
// Ports: clk, reset, d in; q, rise, fall out (N >= 2).
module spi_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [N-1:0] s;
  logic         prev;

  // Chain resets low so a held-low ncs is never
  // mistaken for a fresh frame start after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s    <= '0;
      prev <= 1'b0;
    end else begin
      s    <= {s[N-2:0], d};
      prev <= s[N-1];
    end
  end

  assign q    = s[N-1];
  assign rise = s[N-1] & ~prev;
  assign fall = ~s[N-1] & prev;

endmodule

// File: rtl/pi_spi_rx.sv
// SPI slave receiver for 11-bit sign-magnitude sample frames.
// Ports: clk, reset, bus (pi_spi_rx_if.slave). Option: PEAK_HOLD_EN.
module pi_spi_rx
  import fx_spi_pkg::*;
#(
  parameter int FRAME_BITS  = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset,
  pi_spi_rx_if.slave    bus
);

  localparam logic [3:0] FB = 4'(FRAME_BITS);

  logic sclkRise;
  logic ncsS;
  logic ncsRise;
  logic ncsFall;
  logic sdiS;
  logic unusedSclkQ;
  logic unusedSclkFall;
  logic unusedSdiRise;
  logic unusedSdiFall;

  spi_sync #(.N(SYNC_STAGES)) uSclk (
    .clk  (clk),
    .reset(reset),
    .d    (bus.sclk_in),
    .q    (unusedSclkQ),
    .rise (sclkRise),
    .fall (unusedSclkFall)
  );

  spi_sync #(.N(SYNC_STAGES)) uNcs (
    .clk  (clk),
    .reset(reset),
    .d    (bus.ncs_in),
    .q    (ncsS),
    .rise (ncsRise),
    .fall (ncsFall)
  );

  spi_sync #(.N(SYNC_STAGES)) uSdi (
    .clk  (clk),
    .reset(reset),
    .d    (bus.sdi),
    .q    (sdiS),
    .rise (unusedSdiRise),
    .fall (unusedSdiFall)
  );

  rx_state_t             state;
  rx_state_t             stateNext;
  logic [FRAME_BITS-1:0] shiftQ;
  logic [FRAME_BITS-1:0] shiftNext;
  logic [3:0]            cntQ;
  logic [3:0]            cntNext;
  logic                  latch;
  logic                  err;
  logic                  overflow;
  logic [SAMPLE_W-1:0]   sampleQ;
  logic                  validQ;
  logic                  errQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= WAIT_IDLE;
      shiftQ <= '0;
      cntQ   <= '0;
    end else begin
      state  <= stateNext;
      shiftQ <= shiftNext;
      cntQ   <= cntNext;
    end
  end

  // A same-cycle sclk rise is shifted in before
  // the ncs-rise length check sees the count.
  always_comb begin
    stateNext = state;
    shiftNext = shiftQ;
    cntNext   = cntQ;
    latch     = 1'b0;
    err       = 1'b0;
    overflow  = sclkRise && (cntQ == FB);
    unique case (state)
      WAIT_IDLE: begin
        if (ncsS) stateNext = IDLE;
      end
      IDLE: begin
        if (ncsFall) begin
          stateNext = ACTIVE;
          shiftNext = '0;
          cntNext   = '0;
        end
      end
      ACTIVE: begin
        if (overflow) begin
          stateNext = OVERRUN;
        end else if (sclkRise) begin
          shiftNext = {shiftQ[FRAME_BITS-2:0], sdiS};
          cntNext   = cntQ + 4'd1;
        end
        if (ncsRise) begin
          stateNext = IDLE;
          if (!overflow && cntNext == FB) latch = 1'b1;
          else                             err   = 1'b1;
        end
      end
      OVERRUN: begin
        if (ncsRise) begin
          stateNext = IDLE;
          err       = 1'b1;
        end
      end
      default: stateNext = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sampleQ <= '0;
      validQ  <= 1'b0;
      errQ    <= 1'b0;
    end else begin
      validQ <= latch;
      errQ   <= err;
      if (latch) sampleQ <= sm_to_tc(shiftNext[10:0]);
    end
  end

  assign bus.sample       = sampleQ;
  assign bus.sample_valid = validQ;
  assign bus.frame_err    = errQ;
  assign bus.busy         = (state == ACTIVE) ||
                            (state == OVERRUN);

`ifdef PEAK_HOLD_EN
  logic [MAG_W-1:0] peakQ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peakQ <= '0;
    end else if (latch && shiftNext[9:0] > peakQ) begin
      peakQ <= shiftNext[9:0];
    end
  end

  assign bus.peak_mag = peakQ;
`else
  assign bus.peak_mag = '0;
`endif

endmodule
